// File: rtl/score_multi.sv
// Multi-player saturating score counter with synchronised, edge-detected hit/next buttons
// and seven-segment display of the active score and player. Optional macro: HIT_DEBOUNCE_EN.
module score_multi #(
    parameter int N_PLAYERS       = 2,
    parameter int MAX_SCORE       = 30,
    parameter int HIT_VALUE       = 1,
    parameter int DEBOUNCE_CYCLES = 16,
    localparam int SCORE_W  = $clog2(MAX_SCORE + 1),
    localparam int PLAYER_W = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1
) (
    input  logic                CLOCK_50,
    input  logic                reset_n,
    input  logic                hit_n,
    input  logic                next_n,
    input  logic                clear,
    output logic [SCORE_W-1:0]  score,
    output logic [PLAYER_W-1:0] player,
    output logic                game_over,
    output logic [6:0]          HEX0,
    output logic [6:0]          HEX1,
    output logic [6:0]          HEX2
);

    localparam logic [PLAYER_W-1:0] LAST_P = PLAYER_W'(N_PLAYERS - 1);
    localparam logic [SCORE_W-1:0]  MAX_S  = SCORE_W'(MAX_SCORE);
    localparam logic [SCORE_W:0]    HIT_V  = (SCORE_W + 1)'(HIT_VALUE);

    // Bit 0 is the hit button, bit 1 the next button.
    logic [1:0] btn_n;
    logic [1:0] s1_q, s1_d, s2_q, s2_d, prev_q, prev_d, arm_q, arm_d;
    logic [1:0] vld_q, vld_d;
    logic [1:0] lvl;
    logic [1:0] pulse;

    logic [SCORE_W-1:0]  score_q [N_PLAYERS];
    logic [SCORE_W-1:0]  score_d [N_PLAYERS];
    logic [PLAYER_W-1:0] player_q, player_d;
    logic                game_over_q, game_over_d;
    logic [SCORE_W:0]    sum;

    assign btn_n = {next_n, hit_n};

`ifdef HIT_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       db_q, db_d;
    logic [CNT_W-1:0] cnt_q [2];
    logic [CNT_W-1:0] cnt_d [2];

    always_comb begin
        db_d  = db_q;
        cnt_d = cnt_q;
        for (int i = 0; i < 2; i++) begin
            if (s2_q[i] == db_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_TC) begin
                db_d[i]  = s2_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            db_q  <= 2'b11;
            cnt_q <= '{default: '0};
        end else begin
            db_q  <= db_d;
            cnt_q <= cnt_d;
        end
    end

    assign lvl = db_q;
`else
    if (DEBOUNCE_CYCLES < 2) begin : g_debounce_cfg_unused
    end

    assign lvl = s2_q;
`endif

    // A button is armed only once its real synchronised level has been seen high, so a
    // button held through reset release cannot fire until it is released and pressed again.
    always_comb begin
        s1_d   = btn_n;
        s2_d   = s1_q;
        prev_d = lvl;
        vld_d  = {vld_q[0], 1'b1};
        arm_d  = arm_q | (s2_q & {2{vld_q[1]}});
        pulse  = arm_q & ~lvl & prev_q;
    end

    always_comb begin
        score_d  = score_q;
        player_d = player_q;
        sum      = {1'b0, score_q[player_q]} + HIT_V;
        if (clear) begin
            score_d  = '{default: '0};
            player_d = '0;
        end else begin
            if (pulse[0] && !game_over_q) begin
                score_d[player_q] = (sum > {1'b0, MAX_S}) ? MAX_S : sum[SCORE_W-1:0];
            end
            if (pulse[1]) begin
                player_d = (player_q == LAST_P) ? '0 : player_q + 1'b1;
            end
        end
        game_over_d = 1'b1;
        for (int i = 0; i < N_PLAYERS; i++) begin
            if (score_d[i] != MAX_S) game_over_d = 1'b0;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            s1_q        <= 2'b11;
            s2_q        <= 2'b11;
            prev_q      <= 2'b11;
            arm_q       <= 2'b00;
            vld_q       <= 2'b00;
            score_q     <= '{default: '0};
            player_q    <= '0;
            game_over_q <= 1'b0;
        end else begin
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            prev_q      <= prev_d;
            arm_q       <= arm_d;
            vld_q       <= vld_d;
            score_q     <= score_d;
            player_q    <= player_d;
            game_over_q <= game_over_d;
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    logic [6:0] score_ext;
    logic [3:0] tens, ones;

    always_comb begin
        score_ext = 7'(score_q[player_q]);
        tens      = 4'(score_ext / 7'd10);
        ones      = 4'(score_ext % 7'd10);
    end

    assign score     = score_q[player_q];
    assign player    = player_q;
    assign game_over = game_over_q;
    assign HEX0      = seg7(ones);
    assign HEX1      = seg7(tens);
    assign HEX2      = seg7(4'(player_q) + 4'd1);

endmodule
